// File: rtl/prescaled_cnt.sv
// prescaled_cnt
// Up/down counter with a runtime-programmable clock-enable prescaler,
// a programmable wrap limit, a synchronous load and a terminal-count pulse.
// It produces human-visible step rates from the system clock without
// deriving a new clock.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active-high
//   en       : run enable, gates both the prescaler and stepping
//   num      : prescaler ratio, one step per num enabled cycles (0 and 1 = every cycle)
//   limit    : wrap value, count range is 0..limit
//   dir      : 1 = count up, 0 = count down
//   load     : synchronous load strobe (acts regardless of en)
//   load_val : load value, clamped to limit
//   out      : registered count value
//   tick     : registered one-cycle pulse on every step
//   tc       : registered one-cycle pulse on every wrap
module prescaled_cnt #(
  parameter int WIDTH = 6,
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] num,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             tc
);

  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;

  logic [DIV_W-1:0] div_thr_s;
  logic             step_s;

  // Step threshold: num of 0 behaves like 1. Using >= rather than == means a
  // ratio lowered below the current phase steps on the next enabled edge
  // instead of rolling the prescaler through its full range.
  always_comb begin
    if (num == DIV_ZERO) begin
      div_thr_s = DIV_ZERO;
    end else begin
      div_thr_s = num - DIV_ONE;
    end
    step_s = en && (div_q >= div_thr_s);
  end

  // Next-state logic: load beats step, step beats prescaler advance, else hold.
  always_comb begin
    div_d  = div_q;
    out_d  = out_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    if (load) begin
      div_d = DIV_ZERO;
      if (load_val > limit) begin
        out_d = limit;
      end else begin
        out_d = load_val;
      end
    end else if (step_s) begin
      div_d  = DIV_ZERO;
      tick_d = 1'b1;
      if (dir) begin
        // out above a lowered limit also wraps to 0
        if (out_q >= limit) begin
          out_d = CNT_ZERO;
          tc_d  = 1'b1;
        end else begin
          out_d = out_q + CNT_ONE;
        end
      end else begin
        if (out_q == CNT_ZERO) begin
          out_d = limit;
          tc_d  = 1'b1;
        end else if (out_q > limit) begin
          // limit was lowered under the count: snap down, not a wrap
          out_d = limit;
        end else begin
          out_d = out_q - CNT_ONE;
        end
      end
    end else if (en) begin
      // not at threshold here, so the increment cannot overflow
      div_d = div_q + DIV_ONE;
    end else begin
      div_d = div_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= DIV_ZERO;
      out_q  <= CNT_ZERO;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  assign out  = out_q;
  assign tick = tick_q;
  assign tc   = tc_q;

endmodule

// File: tb/tb_prescaled_cnt.sv
module tb_prescaled_cnt;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] num;
  logic [5:0]  limit;
  logic        dir;
  logic        load;
  logic [5:0]  load_val;
  logic [5:0]  out;
  logic        tick;
  logic        tc;

  int checks;
  int failures;

  // reference model state
  int    m_out;
  longint m_phase;
  bit    m_tick;
  bit    m_tc;

  prescaled_cnt #(.WIDTH(6), .DIV_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .num(num), .limit(limit), .dir(dir),
    .load(load), .load_val(load_val), .out(out), .tick(tick), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic [31:0] num;
    logic [5:0] limit;
    logic [5:0] load_val;
    logic [5:0] exp_out;
    logic       exp_tick;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: count enabled cycles since the last step; step when that count
  // reaches max(num,1).
  task automatic model_edge();
    longint n;
    int lim;
    int lv;
    n   = (num == 32'd0) ? 64'd1 : longint'(num);
    lim = int'(limit);
    lv  = int'(load_val);
    m_tick = 1'b0;
    m_tc   = 1'b0;
    if (rst) begin
      m_out = 0;
      m_phase = 0;
    end else if (load) begin
      m_out = (lv > lim) ? lim : lv;
      m_phase = 0;
    end else if (en) begin
      if (m_phase + 1 >= n) begin
        m_phase = 0;
        m_tick = 1'b1;
        if (dir) begin
          if (m_out >= lim) begin m_out = 0; m_tc = 1'b1; end
          else m_out = m_out + 1;
        end else begin
          if (m_out == 0) begin m_out = lim; m_tc = 1'b1; end
          else if (m_out > lim) m_out = lim;
          else m_out = m_out - 1;
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    failures = 0;
    m_out = 0; m_phase = 0; m_tick = 0; m_tc = 0;
    rst = 1'b1; en = 1'b0; num = 32'd1; limit = 6'd63; dir = 1'b1;
    load = 1'b0; load_val = 6'd0;

    // rst en dir load num limit load_val | out tick tc
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 6'd7, 6'd0, 6'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 6'd7, 6'd0, 6'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 6'd7, 6'd0, 6'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd2, 6'd7, 6'd9, 6'd7, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 6'd7, 6'd0, 6'd7, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 6'd7, 6'd0, 6'd0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 6'd7, 6'd0, 6'd7, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 6'd7, 6'd0, 6'd6, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 6'd3, 6'd0, 6'd3, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd1, 6'd0, 6'd5, 6'd0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 6'd63, 6'd0, 6'd0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; dir = vecs[i].dir; load = vecs[i].load;
      num = vecs[i].num; limit = vecs[i].limit; load_val = vecs[i].load_val;
      cyc();
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].exp_tick));
      chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
    end

    // Up-count wrap: num=4, limit=5
    en = 1'b1; dir = 1'b1; num = 32'd4; limit = 6'd5; load = 1'b0;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      cyc();
      chk($sformatf("up_out_c%0d", c), 32'(out), 32'((c / 4) % 6));
      chk($sformatf("up_tick_c%0d", c), 32'(tick), 32'(c % 4 == 0));
      chk($sformatf("up_tc_c%0d", c), 32'(tc), 32'(c == 24));
    end

    // Down-count full-width wrap: num=1, limit=63
    dir = 1'b0; num = 32'd1; limit = 6'd63;
    do_reset();
    for (int c = 1; c <= 66; c++) begin
      cyc();
      chk($sformatf("dn_out_c%0d", c), 32'(out), 32'((64 - (c % 64)) % 64));
      chk($sformatf("dn_tc_c%0d", c), 32'(tc), 32'(c % 64 == 1));
    end

    // Enable gating: num=3, two enabled cycles then en low for five
    dir = 1'b1; num = 32'd3; limit = 6'd63; en = 1'b1;
    do_reset();
    cyc(); cyc();
    chk("gate_pre_tick", 32'(tick), 32'd0);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("gate_low_tick", 32'(tick), 32'd0);
      chk("gate_low_out", 32'(out), 32'd0);
    end
    en = 1'b1;
    cyc();
    chk("gate_resume_tick", 32'(tick), 32'd1);
    chk("gate_resume_out", 32'(out), 32'd1);

    // num lowered 100 -> 2 with the prescaler at 50
    num = 32'd100; en = 1'b1; dir = 1'b1;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      cyc();
      chk("numlow_no_tick", 32'(tick), 32'd0);
    end
    num = 32'd2;
    cyc();
    chk("numlow_tick", 32'(tick), 32'd1);
    chk("numlow_out", 32'(out), 32'd1);

    // limit lowered 40 -> 10 with out=30, counting up then down
    num = 32'd1; limit = 6'd40; load = 1'b1; load_val = 6'd30;
    cyc();
    load = 1'b0; limit = 6'd10; dir = 1'b1;
    cyc();
    chk("limlow_up_out", 32'(out), 32'd0);
    chk("limlow_up_tc", 32'(tc), 32'd1);
    limit = 6'd40; load = 1'b1; load_val = 6'd30;
    cyc();
    load = 1'b0; limit = 6'd10; dir = 1'b0;
    cyc();
    chk("limlow_dn_out", 32'(out), 32'd10);
    chk("limlow_dn_tc", 32'(tc), 32'd0);
    chk("limlow_dn_tick", 32'(tick), 32'd1);

    // Reset mid-count: out=3, prescaler=2, num=4
    num = 32'd4; limit = 6'd63; dir = 1'b1; en = 1'b1;
    do_reset();
    for (int c = 0; c < 14; c++) cyc();
    chk("midrst_pre_out", 32'(out), 32'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_out", 32'(out), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk($sformatf("midrst_tick_c%0d", c), 32'(tick), 32'(c == 4));
    end

    // Randomised run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 99) < 1);
      load     = ($urandom_range(0, 99) < 4);
      en       = ($urandom_range(0, 99) < 80);
      dir      = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 5) num = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 3) limit = 6'($urandom_range(0, 63));
      load_val = 6'($urandom_range(0, 63));
      cyc();
      chk("rnd_out", 32'(out), 32'(m_out));
      chk("rnd_tick", 32'(tick), 32'(m_tick));
      chk("rnd_tc", 32'(tc), 32'(m_tc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
